// File: rtl/spart_pkg.sv
// Shared SPART definitions: scheduler state encoding, register map addresses
// and the byte width used on every data path.
package spart_pkg;

   localparam int BYTE_W = 8;

   localparam logic [1:0] IOADDR_DATA    = 2'b00;
   localparam logic [1:0] IOADDR_STATUS  = 2'b01;
   localparam logic [1:0] IOADDR_DB_LOW  = 2'b10;
   localparam logic [1:0] IOADDR_DB_HIGH = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_ISSUE    = 2'b01,
      ST_LOAD     = 2'b10,
      ST_WAIT_ACK = 2'b11
   } tx_sched_state_t;

endpackage

// File: rtl/spart_tx_sched_if.sv
// Byte-request bus between the SPART requesters and the transmit scheduler.
interface spart_tx_sched_if
   import spart_pkg::*;
#(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [BYTE_W*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]        req_last;
   logic [NUM_REQ-1:0]        req_ready;

   modport master (
      output req_valid,
      output req_data,
      output req_last,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_data,
      input  req_last,
      output req_ready
   );
endinterface

// File: rtl/spart_rr_pick.sv
// Combinational round-robin picker: searches from the requester after rr_ptr
// and returns the first valid index, wrapping modulo NUM_REQ.
module spart_rr_pick #(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = $clog2(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               any_valid
);

   int               idx_s;
   logic [IDX_W-1:0] cand_s;
   logic             found_s;

   // Walk the rotated priority order and keep the first valid candidate.
   always_comb begin
      winner  = '0;
      found_s = 1'b0;
      idx_s   = 0;
      cand_s  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx_s = int'(rr_ptr) + k;
         if (idx_s >= NUM_REQ) begin
            idx_s = idx_s - NUM_REQ;
         end else begin
            idx_s = idx_s;
         end
         cand_s = IDX_W'(idx_s);
         if (!found_s && req_valid[cand_s]) begin
            winner  = cand_s;
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      any_valid = |req_valid;
   end

endmodule

// File: rtl/spart_tx_sched.sv
// Shares one tx_unit between several byte requesters, arbitrating round-robin
// per message and stepping tx_unit through its transmit/tbr handshake.
module spart_tx_sched
   import spart_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = $clog2(NUM_REQ)
)(
   input  logic               clk,
   input  logic               rst,
   spart_tx_sched_if.slave    req_bus,
   input  logic               tbr,
   output logic [BYTE_W-1:0]  tx_data,
   output logic               transmit,
   output logic [IDX_W-1:0]   grant_id,
   output logic               busy
);

   tx_sched_state_t   state_r;
   tx_sched_state_t   state_nxt_s;
   logic [IDX_W-1:0]  rr_ptr_r;
   logic              last_r;
   logic [IDX_W-1:0]  winner_s;
   logic              any_valid_s;
   logic              accept_s;
   logic              valid_sel_s;
   logic              last_sel_s;
   logic [BYTE_W-1:0] data_sel_s;

   spart_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req_valid (req_bus.req_valid),
      .rr_ptr    (rr_ptr_r),
      .winner    (winner_s),
      .any_valid (any_valid_s)
   );

   // Select the granted requester's valid, byte and last flag.
   always_comb begin
      valid_sel_s = 1'b0;
      last_sel_s  = 1'b0;
      data_sel_s  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == IDX_W'(i)) begin
            valid_sel_s = req_bus.req_valid[i];
            last_sel_s  = req_bus.req_last[i];
            data_sel_s  = req_bus.req_data[i*BYTE_W +: BYTE_W];
         end else begin
            valid_sel_s = valid_sel_s;
         end
      end
   end

   // Next-state and handshake decode; only the granted requester ever sees ready.
   always_comb begin
      state_nxt_s       = state_r;
      accept_s          = 1'b0;
      req_bus.req_ready = '0;
      case (state_r)
         ST_IDLE: begin
            if (any_valid_s) begin
               state_nxt_s = ST_ISSUE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (valid_sel_s && tbr) begin
               accept_s          = 1'b1;
               req_bus.req_ready = NUM_REQ'(1'b1) << grant_id;
               state_nxt_s       = ST_LOAD;
            end else begin
               state_nxt_s = ST_ISSUE;
            end
         end
         ST_LOAD: begin
            state_nxt_s = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (!tbr) begin
               state_nxt_s = last_r ? ST_IDLE : ST_ISSUE;
            end else begin
               state_nxt_s = ST_WAIT_ACK;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, registered outputs and the message lock; rr_ptr moves only when a message completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         tx_data  <= 8'h00;
         transmit <= 1'b0;
         grant_id <= '0;
         busy     <= 1'b0;
         rr_ptr_r <= IDX_W'(NUM_REQ - 1);
         last_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         transmit <= (state_nxt_s == ST_LOAD);
         busy     <= (state_nxt_s != ST_IDLE);
         if (state_r == ST_IDLE && any_valid_s) begin
            grant_id <= winner_s;
         end
         if (accept_s) begin
            tx_data <= data_sel_s;
            last_r  <= last_sel_s;
         end
         if (state_r == ST_WAIT_ACK && !tbr && last_r) begin
            rr_ptr_r <= grant_id;
         end
      end
   end

endmodule

// File: tb/tb_spart_tx_sched.sv
// Directed bench for spart_tx_sched: queue-driven requesters, a behavioural
// tx_unit (tbr low for a fixed frame time) and a byte-order scoreboard.
module tb_spart_tx_sched;
   import spart_pkg::*;

   localparam int FRAME = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tbr = 1'b1;
   logic [7:0] tx_data;
   logic       transmit;
   logic [0:0] grant_id;
   logic       busy;

   spart_tx_sched_if #(.NUM_REQ(2)) req_bus ();

   spart_tx_sched #(.NUM_REQ(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_bus  (req_bus),
      .tbr      (tbr),
      .tx_data  (tx_data),
      .transmit (transmit),
      .grant_id (grant_id),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [8:0] rq0[$];
   logic [8:0] rq1[$];
   logic [7:0] exp_q[$];
   logic [1:0] pend = 2'b00;
   int         n_tx = 0, n_rdy0 = 0, n_rdy1 = 0, tx_cnt = 0;
   logic       prev_tx = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Requesters, tx_unit model and scoreboard: inputs change on the falling edge,
   // outputs are sampled 1 time unit later and acted on at the next falling edge.
   always @(negedge clk) begin
      logic [8:0] h0, h1;
      if (pend[0] && rq0.size() != 0) void'(rq0.pop_front());
      if (pend[1] && rq1.size() != 0) void'(rq1.pop_front());
      if (tx_cnt > 0) begin
         tx_cnt--;
         if (tx_cnt == 0) tbr = 1'b1;
      end
      h0 = (rq0.size() != 0) ? rq0[0] : 9'h000;
      h1 = (rq1.size() != 0) ? rq1[0] : 9'h000;
      req_bus.req_valid = {rq1.size() != 0, rq0.size() != 0};
      req_bus.req_data  = {h1[7:0], h0[7:0]};
      req_bus.req_last  = {h1[8], h0[8]};
      #1;
      pend = req_bus.req_ready;
      if (pend[0]) n_rdy0++;
      if (pend[1]) n_rdy1++;
      if (transmit) begin
         chk("tbr_high_at_load", tbr, 1);
         chk("no_back_to_back_transmit", prev_tx, 0);
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_byte: observed %0h expected none", tx_data);
         end
         if (exp_q.size() != 0) chk("tx_byte_order", tx_data, exp_q.pop_front());
         n_tx++;
         tbr    = 1'b0;
         tx_cnt = FRAME;
      end
      prev_tx = transmit;
   end

   task automatic drain(input string tag);
      int cyc = 0;
      while ((exp_q.size() != 0 || busy || !tbr || rq0.size() != 0 || rq1.size() != 0) && cyc < 2000) begin
         @(negedge clk); #2;
         cyc++;
      end
      chk({tag, "_drain_timeout"}, (cyc < 2000), 1);
   endtask

   task automatic do_reset();
      @(negedge clk); #2 rst = 1'b1;
      @(negedge clk); #2 rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base_tx, base_r0, base_r1, cyc, seen;
      req_bus.req_valid = 2'b00;
      req_bus.req_data  = 16'h0000;
      req_bus.req_last  = 2'b00;

      // Reset with both requesters valid.
      rq0.push_back({1'b1, 8'h5A});
      rq1.push_back({1'b1, 8'hA5});
      repeat (3) begin @(negedge clk); #2; end
      chk("rst_req_ready", req_bus.req_ready, 2'b00);
      chk("rst_transmit", transmit, 0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_grant_id", grant_id, 0);
      rq0.delete(); rq1.delete();
      @(negedge clk); #2 rst = 1'b0;

      // Single byte: latency and pulse counts.
      base_tx = n_tx; base_r0 = n_rdy0;
      rq0.push_back({1'b1, 8'hEF}); exp_q.push_back(8'hEF);
      @(negedge clk); #2;
      chk("lat_idle_busy", busy, 0);
      chk("lat_idle_ready", req_bus.req_ready, 2'b00);
      @(negedge clk); #2;
      chk("lat_issue_ready", req_bus.req_ready, 2'b01);
      chk("lat_issue_busy", busy, 1);
      @(negedge clk); #2;
      chk("lat_load_transmit", transmit, 1);
      chk("lat_load_tx_data", tx_data, 8'hEF);
      @(negedge clk); #2;
      chk("wait_ack_transmit", transmit, 0);
      chk("wait_ack_busy", busy, 1);
      @(negedge clk); #2;
      chk("idle_after_tbr_fall", busy, 0);
      chk("tx_data_held", tx_data, 8'hEF);
      drain("single");
      chk("single_transmit_count", n_tx - base_tx, 1);
      chk("single_ready_count", n_rdy0 - base_r0, 1);

      // Contention from a fresh pointer: 11 then 22, twice.
      do_reset();
      for (int r = 0; r < 2; r++) begin
         rq0.push_back({1'b1, 8'h11}); rq1.push_back({1'b1, 8'h22});
         exp_q.push_back(8'h11); exp_q.push_back(8'h22);
         drain("contention");
      end
      chk("contention_last_grant", grant_id, 1);

      // Message lock: req1 must wait for A3.
      base_tx = n_tx; base_r1 = n_rdy1;
      rq0.push_back({1'b0, 8'hA1}); rq0.push_back({1'b0, 8'hA2}); rq0.push_back({1'b1, 8'hA3});
      exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3); exp_q.push_back(8'h55);
      cyc = 0;
      while (!busy && cyc < 100) begin @(negedge clk); #2; cyc++; end
      chk("lock_grant_timeout", (cyc < 100), 1);
      @(negedge clk); #2;
      rq1.push_back({1'b1, 8'h55});
      cyc = 0;
      while (rq0.size() != 0 && cyc < 500) begin
         @(negedge clk); #2;
         cyc++;
         if (rq0.size() != 0) chk("lock_req1_ready", req_bus.req_ready[1], 0);
      end
      chk("lock_timeout", (cyc < 500), 1);
      drain("lock");
      chk("lock_transmit_count", n_tx - base_tx, 4);
      chk("lock_req1_ready_count", n_rdy1 - base_r1, 1);

      // Backpressure: req1 arrives while tx_unit is mid-frame.
      base_tx = n_tx;
      rq0.push_back({1'b1, 8'h66});
      exp_q.push_back(8'h66); exp_q.push_back(8'h77);
      cyc = 0;
      while (tbr && cyc < 100) begin @(negedge clk); #2; cyc++; end
      chk("bp_frame_timeout", (cyc < 100), 1);
      rq1.push_back({1'b1, 8'h77});
      cyc = 0;
      while (!tbr && cyc < 100) begin
         @(negedge clk); #2;
         cyc++;
         if (!tbr) chk("bp_no_ready", req_bus.req_ready, 2'b00);
      end
      drain("backpressure");
      chk("bp_transmit_count", n_tx - base_tx, 2);

      // Reset in WAIT_ACK of byte 2 of 3.
      rq0.push_back({1'b0, 8'hB1}); rq0.push_back({1'b0, 8'hB2}); rq0.push_back({1'b1, 8'hB3});
      exp_q.push_back(8'hB1); exp_q.push_back(8'hB2);
      seen = 0; cyc = 0;
      while (seen < 2 && cyc < 500) begin
         @(negedge clk); #2;
         cyc++;
         if (transmit) seen++;
      end
      chk("midrst_reach_timeout", (cyc < 500), 1);
      @(negedge clk); #2;
      chk("midrst_pre_busy", busy, 1);
      chk("midrst_pre_bytes_done", exp_q.size(), 0);
      rst = 1'b1;
      #1;
      chk("midrst_req_ready", req_bus.req_ready, 2'b00);
      chk("midrst_transmit", transmit, 0);
      chk("midrst_tx_data", tx_data, 8'h00);
      chk("midrst_busy", busy, 0);
      chk("midrst_grant_id", grant_id, 0);
      rq0.delete();
      @(negedge clk); #2 rst = 1'b0;
      rq0.push_back({1'b1, 8'hC0}); rq1.push_back({1'b1, 8'hC1});
      exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
      drain("after_reset");
      chk("after_reset_last_grant", grant_id, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
